// File: rtl/csmulti_pkg.sv
// csmulti_pkg: shared state type and default widths for the carry-save multiplier MAC back end
package csmulti_pkg;
   typedef enum logic {ACCUM, DRAIN} state_t;
   localparam int def_bitsize  = 8;
   localparam int def_accwidth = 2 * def_bitsize + 8;
   localparam int def_cntwidth = 8;
endpackage

// File: rtl/csmulti_mac_accum_if.sv
// csmulti_mac_accum_if: product input and result output handshakes of the MAC accumulator
interface csmulti_mac_accum_if
   import csmulti_pkg::*;
#(
   parameter int bitsize  = def_bitsize,
   parameter int accwidth = def_accwidth,
   parameter int cntwidth = def_cntwidth
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_last;
   logic [2*bitsize-1:0]  product;
   logic                  out_valid;
   logic                  out_ready;
   logic [accwidth-1:0]   acc_out;
   logic [cntwidth-1:0]   term_count;
   logic                  overflow;
   modport master (
      output in_valid, in_last, product, out_ready,
      input  in_ready, out_valid, acc_out, term_count, overflow
   );
   modport slave (
      input  in_valid, in_last, product, out_ready,
      output in_ready, out_valid, acc_out, term_count, overflow
   );
endinterface

// File: rtl/csmulti_mac_accum.sv
// csmulti_mac_accum: sums unsigned product terms per group and holds the result until taken
module csmulti_mac_accum
   import csmulti_pkg::*;
#(
   parameter int bitsize  = def_bitsize,
   parameter int accwidth = def_accwidth,
   parameter int cntwidth = def_cntwidth
) (
   input logic                clk,
   input logic                rst,
   csmulti_mac_accum_if.slave bus
);
   state_t              state_q, state_d;
   logic [accwidth-1:0] acc_q, acc_d, acc_out_q, acc_out_d;
   logic [cntwidth-1:0] cnt_q, cnt_d, term_count_q, term_count_d, cnt_inc;
   logic                ovf_q, ovf_d, overflow_q, overflow_d, ovf_nxt;
   logic                accept, load, clear;
   logic [accwidth:0]   sum;

   // state, running group totals and the presented result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ACCUM;
         acc_q        <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         acc_out_q    <= '0;
         term_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         acc_out_q    <= acc_out_d;
         term_count_q <= term_count_d;
         overflow_q   <= overflow_d;
      end
   end

   // leave ACCUM on an accepted last term, return once the result is taken
   always_comb begin
      state_d = (state_q == ACCUM) ? ((bus.in_valid && bus.in_last) ? DRAIN : ACCUM)
                                   : (bus.out_ready ? ACCUM : DRAIN);
   end

   // one extra sum bit catches the carry-out that makes overflow sticky
   always_comb begin
      accept       = (state_q == ACCUM) && bus.in_valid;
      load         = accept && bus.in_last;
      clear        = (state_q == DRAIN) && bus.out_ready;
      sum          = {1'b0, acc_q} + {{(accwidth + 1 - 2 * bitsize){1'b0}}, bus.product};
      cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      ovf_nxt      = ovf_q | sum[accwidth];
      acc_d        = clear ? '0 : accept ? sum[accwidth-1:0] : acc_q;
      cnt_d        = clear ? '0 : accept ? cnt_inc : cnt_q;
      ovf_d        = clear ? 1'b0 : accept ? ovf_nxt : ovf_q;
      acc_out_d    = load ? sum[accwidth-1:0] : acc_out_q;
      term_count_d = load ? cnt_inc : term_count_q;
      overflow_d   = load ? ovf_nxt : overflow_q;
   end

   // handshake flags depend on state alone
   always_comb begin
      bus.in_ready   = (state_q == ACCUM);
      bus.out_valid  = (state_q == DRAIN);
      bus.acc_out    = acc_out_q;
      bus.term_count = term_count_q;
      bus.overflow   = overflow_q;
   end
endmodule

// File: tb/tb_csmulti_mac_accum.sv
// tb_csmulti_mac_accum: directed-vector bench for the MAC accumulator
module tb_csmulti_mac_accum;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   csmulti_mac_accum_if #(.bitsize(8), .accwidth(24), .cntwidth(8)) bus ();

   csmulti_mac_accum #(.bitsize(8), .accwidth(24), .cntwidth(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic drive_term(input logic [15:0] val, input logic last);
      bus.in_valid = 1'b1;
      bus.product  = val;
      bus.in_last  = last;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      checks++;
      if (bus.acc_out !== 24'd0) begin errors++; $display("FAIL reset_acc_out got %0d want 0", bus.acc_out); end
      checks++;
      if (bus.term_count !== 8'd0) begin errors++; $display("FAIL reset_term_count got %0d want 0", bus.term_count); end
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
   endtask

   task automatic test_basic;
      bus.out_ready = 1'b1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_before got %b want 1", bus.in_ready); end
      drive_term(16'd6, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", bus.out_valid); end
      drive_term(16'd20, 1'b0);
      drive_term(16'd65025, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b want 1", bus.out_valid); end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_drain got %b want 0", bus.in_ready); end
      checks++;
      if (bus.acc_out !== 24'd65051) begin errors++; $display("FAIL basic_acc_out got %0d want 65051", bus.acc_out); end
      checks++;
      if (bus.term_count !== 8'd3) begin errors++; $display("FAIL basic_term_count got %0d want 3", bus.term_count); end
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got %b want 0", bus.overflow); end
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_return got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_backpressure;
      bus.out_ready = 1'b0;
      drive_term(16'd6, 1'b0);
      drive_term(16'd20, 1'b0);
      drive_term(16'd65025, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_last  = 1'b1;
      bus.product  = 16'd999;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.acc_out !== 24'd65051 || bus.term_count !== 8'd3) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got ready=%b valid=%b acc=%0d cnt=%0d want 0/1/65051/3",
                     i, bus.in_ready, bus.out_valid, bus.acc_out, bus.term_count);
         end
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
      end
      drive_term(16'd5, 1'b1);
      checks++;
      if (bus.acc_out !== 24'd5 || bus.term_count !== 8'd1) begin
         errors++; $display("FAIL bp_no_absorb got acc=%0d cnt=%0d want 5/1", bus.acc_out, bus.term_count);
      end
      @(negedge clk);
   endtask

   task automatic test_single_zero;
      drive_term(16'd0, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.acc_out !== 24'd0 || bus.term_count !== 8'd1 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL zero_group got valid=%b acc=%0d cnt=%0d ovf=%b want 1/0/1/0",
                  bus.out_valid, bus.acc_out, bus.term_count, bus.overflow);
      end
      @(negedge clk);
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 258; i++) drive_term(16'd65025, 1'b0);
      drive_term(16'd65025, 1'b1);
      checks++;
      if (bus.acc_out !== 24'd64259) begin errors++; $display("FAIL ovf_acc_out got %0d want 64259", bus.acc_out); end
      checks++;
      if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
      checks++;
      if (bus.term_count !== 8'd255) begin errors++; $display("FAIL ovf_sat_count got %0d want 255", bus.term_count); end
      @(negedge clk);
      drive_term(16'd1, 1'b1);
      checks++;
      if (bus.acc_out !== 24'd1 || bus.overflow !== 1'b0 || bus.term_count !== 8'd1) begin
         errors++;
         $display("FAIL ovf_next_group got acc=%0d ovf=%b cnt=%0d want 1/0/1", bus.acc_out, bus.overflow, bus.term_count);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      drive_term(16'd100, 1'b0);
      drive_term(16'd200, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.acc_out !== 24'd0 || bus.term_count !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset_state got ready=%b valid=%b acc=%0d cnt=%0d want 1/0/0/0",
                  bus.in_ready, bus.out_valid, bus.acc_out, bus.term_count);
      end
      drive_term(16'd7, 1'b1);
      checks++;
      if (bus.acc_out !== 24'd7 || bus.term_count !== 8'd1) begin
         errors++; $display("FAIL mid_reset_group got acc=%0d cnt=%0d want 7/1", bus.acc_out, bus.term_count);
      end
      @(negedge clk);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.product   = '0;
      bus.out_ready = 1'b0;
      test_reset;
      test_basic;
      test_backpressure;
      test_single_zero;
      test_overflow;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
